// File: rtl/sprite_pkg.sv
// Shared screen geometry, motion FSM encoding and the per-axis reflection step.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [1:0] motion_state_t;

    localparam motion_state_t StIdle  = 2'd0;
    localparam motion_state_t StWait  = 2'd1;
    localparam motion_state_t StStepX = 2'd2;
    localparam motion_state_t StStepY = 2'd3;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       flip;
    } axis_step_t;

    // One motion step on a single axis; reflects off 0 and max_pos.
    // Speed <= 15 is far below any border distance, so one reflection suffices.
    function automatic axis_step_t axis_step(input logic [9:0] pos,
                                             input logic [3:0] speed,
                                             input logic       dir,
                                             input logic [9:0] max_pos);
        logic signed [10:0] p;
        logic signed [10:0] s;
        logic signed [10:0] m;
        logic signed [10:0] nxt;
        axis_step_t         r;
        p      = signed'({1'b0, pos});
        s      = signed'({7'd0, speed});
        m      = signed'({1'b0, max_pos});
        r.dir  = dir;
        r.flip = 1'b0;
        if (dir == 1'b0) begin
            nxt = p + s;
            if (nxt >= m && speed != 4'd0) begin
                // 2*m - nxt, kept within 11 bits
                nxt    = m - (nxt - m);
                r.dir  = 1'b1;
                r.flip = 1'b1;
            end
        end else begin
            nxt = p - s;
            if (nxt <= 11'sd0 && speed != 4'd0) begin
                nxt    = -nxt;
                r.dir  = 1'b0;
                r.flip = 1'b1;
            end
        end
        r.pos = nxt[9:0];
        return r;
    endfunction

endpackage

// File: rtl/sprite_motion_if.sv
// Control and position bundle between the motion driver and the sprite position generator.
interface sprite_motion_if;

    logic       vsync;
    logic       enable;
    logic [3:0] speed_x;
    logic [3:0] speed_y;
    logic       load;
    logic [9:0] load_x;
    logic [9:0] load_y;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       dir_x;
    logic       dir_y;
    logic       bounce;
    logic       frame_tick;

    modport master (
        output vsync, enable, speed_x, speed_y, load, load_x, load_y,
        input  sprite_x, sprite_y, dir_x, dir_y, bounce, frame_tick
    );

    modport slave (
        input  vsync, enable, speed_x, speed_y, load, load_x, load_y,
        output sprite_x, sprite_y, dir_x, dir_y, bounce, frame_tick
    );

endinterface

// File: rtl/vsync_edge_detect.sv
// Brings raw vsync into the clk domain and emits a one-cycle pulse per falling edge.
module vsync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_q;

    // Two-flop synchronizer, edge history and registered tick (3 cycles after the fall).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= prev_q & ~sync2_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/sprite_motion.sv
// Bouncing sprite position generator; steps once every FRAME_DIV frames.
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W  = 32,
    parameter int unsigned SPRITE_H  = 32,
    parameter int unsigned INIT_X    = 304,
    parameter int unsigned INIT_Y    = 224,
    parameter int unsigned FRAME_DIV = 1
) (
    input logic            clk,
    input logic            reset,
    sprite_motion_if.slave bus
);

    localparam logic [9:0] MaxX      = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0] MaxY      = 10'(SCREEN_H - SPRITE_H);
    localparam logic [9:0] InitX     = 10'(INIT_X);
    localparam logic [9:0] InitY     = 10'(INIT_Y);
    localparam logic [7:0] FrameLast = 8'(FRAME_DIV - 1);

    logic          frame_tick;
    logic          step_req;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    motion_state_t state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic          flip_x_q, flip_x_d;
    logic          bounce_q, bounce_d;
    axis_step_t    step_x, step_y;

    vsync_edge_detect u_vsync_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .vsync      (bus.vsync),
        .frame_tick (frame_tick)
    );

    assign step_req = frame_tick && bus.enable && (frame_cnt_q == FrameLast);
    assign step_x   = axis_step(x_q, bus.speed_x, dir_x_q, MaxX);
    assign step_y   = axis_step(y_q, bus.speed_y, dir_y_q, MaxY);

    // Frame divider: counts ticks while enabled, wraps on the stepping tick.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (bus.load) begin
            frame_cnt_d = 8'd0;
        end else if (frame_tick && bus.enable) begin
            frame_cnt_d = step_req ? 8'd0 : frame_cnt_q + 8'd1;
        end
    end

    // Motion FSM and position update; load overrides everything and aborts a step.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        flip_x_d = flip_x_q;
        bounce_d = 1'b0;
        if (bus.load) begin
            x_d      = (bus.load_x > MaxX) ? MaxX : bus.load_x;
            y_d      = (bus.load_y > MaxY) ? MaxY : bus.load_y;
            flip_x_d = 1'b0;
            state_d  = bus.enable ? StWait : StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.enable) state_d = StWait;
                end
                StWait: begin
                    if (step_req) state_d = StStepX;
                    else if (!bus.enable) state_d = StIdle;
                end
                StStepX: begin
                    x_d      = step_x.pos;
                    dir_x_d  = step_x.dir;
                    flip_x_d = step_x.flip;
                    state_d  = StStepY;
                end
                StStepY: begin
                    y_d      = step_y.pos;
                    dir_y_d  = step_y.dir;
                    bounce_d = flip_x_q | step_y.flip;
                    state_d  = bus.enable ? StWait : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
            state_q     <= StIdle;
            x_q         <= InitX;
            y_q         <= InitY;
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            flip_x_q    <= 1'b0;
            bounce_q    <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            flip_x_q    <= flip_x_d;
            bounce_q    <= bounce_d;
        end
    end

    assign bus.sprite_x   = x_q;
    assign bus.sprite_y   = y_q;
    assign bus.dir_x      = dir_x_q;
    assign bus.dir_y      = dir_y_q;
    assign bus.bounce     = bounce_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_sprite_motion.sv
// Drives two instances (FRAME_DIV 1 and 4) with shared stimulus against a frame-level model.
module tb_sprite_motion;

    localparam int MAX_X  = 608;
    localparam int MAX_Y  = 448;
    localparam int INIT_X = 304;
    localparam int INIT_Y = 224;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sprite_motion_if bus_a ();
    sprite_motion_if bus_b ();

    sprite_motion #(.FRAME_DIV(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sprite_motion #(.FRAME_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: one entry per instance
    int mx[2], my[2], mdx[2], mdy[2], mcnt[2];
    int div[2] = '{1, 4};
    bit cur_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input bit en, input int sx, input int sy);
        cur_en        = en;
        bus_a.enable  = en;
        bus_b.enable  = en;
        bus_a.speed_x = 4'(sx);
        bus_b.speed_x = 4'(sx);
        bus_a.speed_y = 4'(sy);
        bus_b.speed_y = 4'(sy);
    endtask

    task automatic drive_load(input bit l, input int lx, input int ly);
        bus_a.load   = l;
        bus_b.load   = l;
        bus_a.load_x = 10'(lx);
        bus_b.load_x = 10'(lx);
        bus_a.load_y = 10'(ly);
        bus_b.load_y = 10'(ly);
    endtask

    task automatic set_vsync(input bit v);
        bus_a.vsync = v;
        bus_b.vsync = v;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = INIT_X; my[k] = INIT_Y; mdx[k] = 0; mdy[k] = 0; mcnt[k] = 0;
        end
    endtask

    task automatic model_load(input int lx, input int ly);
        for (int k = 0; k < 2; k++) begin
            mx[k]   = (lx > MAX_X) ? MAX_X : lx;
            my[k]   = (ly > MAX_Y) ? MAX_Y : ly;
            mcnt[k] = 0;
        end
    endtask

    // Move p by s along d; mirror about the border if it is reached or crossed.
    task automatic model_axis(inout int p, inout int d, input int s, input int lim,
                              output bit flip);
        int np;
        flip = 1'b0;
        if (s == 0) return;
        np = (d == 0) ? p + s : p - s;
        if (d == 0 && np >= lim) begin
            np   = 2 * lim - np;
            flip = 1'b1;
        end else if (d == 1 && np <= 0) begin
            np   = -np;
            flip = 1'b1;
        end
        if (flip) d = 1 - d;
        p = np;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_a_x"},  32'(bus_a.sprite_x), 32'(mx[0]));
        chk({tag, "_a_y"},  32'(bus_a.sprite_y), 32'(my[0]));
        chk({tag, "_a_dx"}, 32'(bus_a.dir_x),    32'(mdx[0]));
        chk({tag, "_a_dy"}, 32'(bus_a.dir_y),    32'(mdy[0]));
        chk({tag, "_b_x"},  32'(bus_b.sprite_x), 32'(mx[1]));
        chk({tag, "_b_y"},  32'(bus_b.sprite_y), 32'(my[1]));
        chk({tag, "_b_dx"}, 32'(bus_b.dir_x),    32'(mdx[1]));
        chk({tag, "_b_dy"}, 32'(bus_b.dir_y),    32'(mdy[1]));
    endtask

    task automatic load_now(input string tag, input int lx, input int ly);
        @(posedge clk); #1;
        drive_load(1'b1, lx, ly);
        @(posedge clk); #1;
        drive_load(1'b0, 0, 0);
        model_load(lx, ly);
        check_state(tag);
    endtask

    // One vsync frame. load_cyc in {3,4,6,7} strobes load in that cycle after the fall
    // (3 = tick cycle, 4 = inside a step); do_reset pulses reset during the step.
    task automatic run_frame(input string tag, input int load_cyc, input int lx, input int ly,
                             input bit do_reset);
        int first_a, first_b, ticks_a, ticks_b;
        int bnc[2];
        bit stepping, fx, fy;
        first_a = -1; first_b = -1; ticks_a = 0; ticks_b = 0; bnc[0] = 0; bnc[1] = 0;
        @(posedge clk); #1;
        set_vsync(1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus_a.frame_tick === 1'b1) begin
                ticks_a++;
                if (first_a < 0) first_a = c;
            end
            if (bus_b.frame_tick === 1'b1) begin
                ticks_b++;
                if (first_b < 0) first_b = c;
            end
            if (bus_a.bounce === 1'b1) bnc[0]++;
            if (bus_b.bounce === 1'b1) bnc[1]++;
            if (do_reset && c == 5) begin
                reset = 1'b0;
                model_reset();
                check_state({tag, "_rst"});
                chk({tag, "_rst_a_bounce"}, 32'(bus_a.bounce), 32'd0);
                chk({tag, "_rst_b_bounce"}, 32'(bus_b.bounce), 32'd0);
            end
            if (c == load_cyc) drive_load(1'b1, lx, ly);
            else drive_load(1'b0, 0, 0);
            if (do_reset && c == 4) begin
                reset = 1'b1;
                set_vsync(1'b1);
            end
            if (c == 6) set_vsync(1'b1);
        end
        chk({tag, "_a_tick_at"}, 32'(first_a), 32'd3);
        chk({tag, "_b_tick_at"}, 32'(first_b), 32'd3);
        chk({tag, "_a_ticks"},   32'(ticks_a), 32'd1);
        chk({tag, "_b_ticks"},   32'(ticks_b), 32'd1);
        for (int k = 0; k < 2; k++) begin
            int exp_b;
            exp_b = 0;
            if (!do_reset) begin
                stepping = 1'b0;
                if (load_cyc != 3 && cur_en) begin
                    mcnt[k]++;
                    if (mcnt[k] == div[k]) begin
                        mcnt[k]  = 0;
                        stepping = 1'b1;
                    end
                end
                if (stepping && load_cyc != 4) begin
                    model_axis(mx[k], mdx[k], int'(bus_a.speed_x), MAX_X, fx);
                    model_axis(my[k], mdy[k], int'(bus_a.speed_y), MAX_Y, fy);
                    exp_b = (fx || fy) ? 1 : 0;
                end
            end
            chk($sformatf("%s_%0d_bounce", tag, k), 32'(bnc[k]), 32'(exp_b));
        end
        if (!do_reset && load_cyc != 0) model_load(lx, ly);
        check_state(tag);
    endtask

    initial begin
        reset = 1'b1;
        set_vsync(1'b1);
        set_inputs(1'b0, 0, 0);
        drive_load(1'b0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_a_bounce", 32'(bus_a.bounce), 32'd0);
        chk("reset_a_tick",   32'(bus_a.frame_tick), 32'd0);
        chk("reset_b_tick",   32'(bus_b.frame_tick), 32'd0);
        reset = 1'b0;

        // Plain motion
        set_inputs(1'b1, 4, 2);
        for (int i = 0; i < 3; i++) run_frame($sformatf("move%0d", i), 0, 0, 0, 1'b0);
        chk("move_a_x_final", 32'(bus_a.sprite_x), 32'd316);
        chk("move_a_y_final", 32'(bus_a.sprite_y), 32'd230);

        // Right border reflection
        load_now("ld600", 600, 100);
        set_inputs(1'b1, 10, 2);
        run_frame("bounce_r", 0, 0, 0, 1'b0);
        chk("bounce_r_x_606", 32'(bus_a.sprite_x), 32'd606);

        // Bottom border to turn y around, then both axes off the top-left corner
        load_now("ld440", 300, 440);
        set_inputs(1'b1, 0, 10);
        run_frame("bounce_b", 0, 0, 0, 1'b0);
        set_inputs(1'b1, 5, 2);
        load_now("ld3_2", 3, 2);
        run_frame("corner", 0, 0, 0, 1'b0);
        chk("corner_a_x_2", 32'(bus_a.sprite_x), 32'd2);
        chk("corner_a_y_0", 32'(bus_a.sprite_y), 32'd0);

        // Frame divider, then freeze while disabled
        load_now("ld_div", 100, 100);
        set_inputs(1'b1, 3, 3);
        for (int i = 0; i < 8; i++) run_frame($sformatf("div%0d", i), 0, 0, 0, 1'b0);
        set_inputs(1'b0, 3, 3);
        for (int i = 0; i < 2; i++) run_frame($sformatf("off%0d", i), 0, 0, 0, 1'b0);
        set_inputs(1'b1, 3, 3);

        // Load coinciding with the step request, clamped
        run_frame("ld_step", 3, 700, 100, 1'b0);
        chk("ld_step_a_x_608", 32'(bus_a.sprite_x), 32'd608);

        // Reset in the middle of a step
        run_frame("rst_step", 0, 0, 0, 1'b1);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            int r, lc;
            int lcs[4] = '{3, 4, 6, 7};
            set_inputs($urandom_range(0, 7) != 0, $urandom_range(0, 15), $urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            lc = 0;
            if (r == 0) lc = lcs[$urandom_range(0, 3)];
            if (r == 1) load_now($sformatf("rld%0d", i), $urandom_range(0, 1023),
                                 $urandom_range(0, 1023));
            run_frame($sformatf("rnd%0d", i), lc, $urandom_range(0, 1023),
                      $urandom_range(0, 1023), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
